// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - clock-enable generator feeding the 8-bit timer counter
// Internal /2../16 divider or synchronized external tick, with selects updated only at safe points.
module timer_prescaler #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pre_en,
   input  logic [1:0] cks,
   input  logic       ext_sel,
   input  logic       tclk_in,
   output logic       clk_ena,
   output logic [3:0] div_cnt,
   output logic [1:0] cks_act,
   output logic       ext_act
);

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync_q;
   logic                   sync_d1;
   logic                   tap_d1;

   logic                   upd;
   logic [3:0]             div_nxt;
   logic [1:0]             cks_nxt;
   logic                   ext_nxt;
   logic                   tap;
   logic                   tap_nxt;
   logic                   int_edge;
   logic                   ext_edge;
   logic                   sync_reload;

   always_comb begin
      upd      = ~pre_en | (div_cnt == 4'hF);
      div_nxt  = pre_en ? (div_cnt + 4'd1) : 4'd0;
      cks_nxt  = upd ? cks : cks_act;
      ext_nxt  = upd ? ext_sel : ext_act;
      sync_q   = sync_ff[SYNC_STAGES-1];
      tap      = div_cnt[cks_act];
      tap_nxt  = div_nxt[cks_nxt];
      int_edge = tap & ~tap_d1;
      ext_edge = sync_q & ~sync_d1;
      // A steady external source keeps its edge history across wraps so a tick
      // landing on a wrap edge is not swallowed; only a switch into it is masked.
      sync_reload = upd & (~pre_en | (ext_sel & ~ext_act));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt <= 4'd0;
         cks_act <= 2'd0;
         ext_act <= 1'b0;
         sync_ff <= '0;
         sync_d1 <= 1'b0;
         tap_d1  <= 1'b0;
         clk_ena <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         cks_act <= cks_nxt;
         ext_act <= ext_nxt;
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], tclk_in};
         tap_d1  <= upd ? tap_nxt : tap;
         sync_d1 <= sync_reload ? sync_ff[SYNC_STAGES-2] : sync_q;
         clk_ena <= pre_en & (ext_act ? ext_edge : int_edge);
      end
   end

endmodule

// File: tb/tb_timer_prescaler.sv
// tb/tb_timer_prescaler.sv - self-checking bench for timer_prescaler
// Rate table plus hand sequences; expected pulse edges go through a scoreboard queue.
module tb_timer_prescaler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pre_en;
   logic [1:0] cks;
   logic       ext_sel;
   logic       tclk_in;
   logic       clk_ena;
   logic [3:0] div_cnt;
   logic [1:0] cks_act;
   logic       ext_act;

   timer_prescaler #(.SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .pre_en  (pre_en),
      .cks     (cks),
      .ext_sel (ext_sel),
      .tclk_in (tclk_in),
      .clk_ena (clk_ena),
      .div_cnt (div_cnt),
      .cks_act (cks_act),
      .ext_act (ext_act)
   );

   always #5 clk = ~clk;

   // Small 8-bit timer counter driven by clk_ena
   logic       cnt_load;
   logic       cnt_up;
   logic [7:0] tcnt;
   logic       ovf;
   logic       unf;

   always_ff @(posedge clk) begin
      if (!rst_n || cnt_load) begin
         tcnt <= 8'd0;
         ovf  <= 1'b0;
         unf  <= 1'b0;
      end else if (clk_ena) begin
         if (cnt_up) begin
            tcnt <= tcnt + 8'd1;
            if (tcnt == 8'hFF) ovf <= 1'b1;
         end else begin
            tcnt <= tcnt - 8'd1;
            if (tcnt == 8'h00) unf <= 1'b1;
         end
      end
   end

   typedef struct {
      logic [1:0] cks;
      int         first;
      int         period;
      int         count;
   } rate_vec_t;

   rate_vec_t rate_tab [4];
   int        exp_q [$];
   int        tests  = 0;
   int        failed = 0;
   int        edge_n = 0;
   int        pulses = 0;
   logic      prev_ena = 1'b0;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   // Advance one edge and reconcile any clk_ena pulse against the scoreboard
   task automatic sb_step(input string name);
      tick();
      if (clk_ena) begin
         pulses++;
         check({name, " pulse width"}, int'(prev_ena), 0);
         if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL %s unexpected pulse: edge %0d, required none", name, edge_n);
         end else begin
            check({name, " pulse edge"}, edge_n, exp_q.pop_front());
         end
      end
      prev_ena = clk_ena;
   endtask

   task automatic do_reset(input logic [1:0] c, input logic x);
      rst_n   = 1'b0;
      pre_en  = 1'b0;
      cks     = c;
      ext_sel = x;
      tclk_in = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      edge_n   = 0;
      pulses   = 0;
      prev_ena = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      int n;
      int guard;
      int bad;
      int ph;
      int glitch;

      rate_tab[0] = '{cks: 2'd0, first: 2, period: 2,  count: 128};
      rate_tab[1] = '{cks: 2'd1, first: 3, period: 4,  count: 64};
      rate_tab[2] = '{cks: 2'd2, first: 5, period: 8,  count: 32};
      rate_tab[3] = '{cks: 2'd3, first: 9, period: 16, count: 16};

      cnt_load = 1'b0;
      cnt_up   = 1'b1;

      // Reset and idle
      rst_n = 1'b0; pre_en = 1'b1; cks = 2'd3; ext_sel = 1'b1; tclk_in = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("reset clk_ena", int'(clk_ena), 0);
      check("reset div_cnt", int'(div_cnt), 0);
      check("reset cks_act", int'(cks_act), 0);
      check("reset ext_act", int'(ext_act), 0);
      rst_n = 1'b1; pre_en = 1'b0; cks = 2'd0; ext_sel = 1'b0; tclk_in = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (clk_ena || div_cnt != 4'd0 || cks_act != 2'd0 || ext_act) bad++;
      end
      check("idle activity cycles", bad, 0);

      // Rate table
      for (int v = 0; v < 4; v++) begin
         do_reset(rate_tab[v].cks, 1'b0);
         check("rate cks_act", int'(cks_act), int'(rate_tab[v].cks));
         pre_en = 1'b1;
         for (int e = rate_tab[v].first; e <= 256; e += rate_tab[v].period) exp_q.push_back(e);
         sb_step("rate");
         check("rate div_cnt after edge 1", int'(div_cnt), 1);
         for (int e = 2; e <= 256; e++) sb_step("rate");
         check("rate pulses per 256", pulses, rate_tab[v].count);
         check("rate leftover expected", exp_q.size(), 0);
      end

      // Safe switch /16 -> /2 at div_cnt=5
      do_reset(2'd3, 1'b0);
      pre_en = 1'b1;
      exp_q.push_back(9);
      for (int e = 18; e <= 40; e += 2) exp_q.push_back(e);
      for (int e = 1; e <= 40; e++) begin
         sb_step("switch");
         if (edge_n == 5) begin
            check("switch div_cnt at change", int'(div_cnt), 5);
            cks = 2'd0;
         end
         if (edge_n == 15) check("switch cks_act before wrap", int'(cks_act), 3);
         if (edge_n == 16) begin
            check("switch cks_act at wrap", int'(cks_act), 0);
            check("switch div_cnt at wrap", int'(div_cnt), 0);
            check("switch no pulse at wrap", int'(clk_ena), 0);
         end
      end
      check("switch leftover expected", exp_q.size(), 0);

      // External ticks: 3 high / 3 low, first rise before edge 4
      do_reset(2'd0, 1'b1);
      check("ext ext_act", int'(ext_act), 1);
      pre_en = 1'b1;
      for (int k = 0; k < 10; k++) exp_q.push_back(6 + 6 * k);
      for (int e = 1; e <= 66; e++) begin
         ph = e - 4;
         tclk_in = (ph >= 0 && ph < 60 && (ph % 6) < 3);
         sb_step("ext");
      end
      check("ext pulse count", pulses, 10);
      check("ext leftover expected", exp_q.size(), 0);
      glitch = 0;
      for (int e = 67; e <= 80; e++) begin
         tclk_in = (e == 70);
         tick();
         if (clk_ena) glitch++;
      end
      check("ext glitch at most one", int'(glitch <= 1), 1);

      // Stop mid-count
      do_reset(2'd0, 1'b0);
      pre_en = 1'b1;
      exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(6);
      for (int e = 1; e <= 6; e++) sb_step("stop");
      check("stop pulse in flight", int'(clk_ena), 1);
      pre_en = 1'b0;
      sb_step("stop");
      check("stop div_cnt", int'(div_cnt), 0);
      check("stop clk_ena", int'(clk_ena), 0);
      for (int i = 0; i < 20; i++) sb_step("stop");
      check("stop pulse count", pulses, 3);

      // Reset one cycle before a pending /16 pulse
      do_reset(2'd3, 1'b0);
      pre_en = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("rstmid div_cnt", int'(div_cnt), 8);
      rst_n = 1'b0;
      tick();
      check("rstmid clk_ena", int'(clk_ena), 0);
      check("rstmid div_cnt", int'(div_cnt), 0);
      check("rstmid cks_act", int'(cks_act), 0);
      check("rstmid ext_act", int'(ext_act), 0);
      rst_n = 1'b1; cks = 2'd0;
      edge_n = 0; pulses = 0; prev_ena = 1'b0; exp_q.delete();
      exp_q.push_back(2); exp_q.push_back(4);
      for (int i = 0; i < 4; i++) sb_step("restart");
      check("restart pulse count", pulses, 2);

      // Counter integration
      do_reset(2'd0, 1'b0);
      cnt_load = 1'b1;
      tick();
      cnt_load = 1'b0; cnt_up = 1'b1; pre_en = 1'b1;
      n = 0; guard = 0;
      while (n < 256 && guard < 2000) begin
         tick();
         guard++;
         if (clk_ena) n++;
      end
      check("cnt ticks seen", n, 256);
      check("cnt value before 256th", int'(tcnt), 255);
      check("cnt ovf before 256th", int'(ovf), 0);
      tick();
      check("cnt value after 256th", int'(tcnt), 0);
      check("cnt ovf after 256th", int'(ovf), 1);
      cnt_up = 1'b0;
      guard = 0;
      while (!clk_ena && guard < 100) begin
         tick();
         guard++;
      end
      check("cnt down tick seen", int'(clk_ena), 1);
      tick();
      check("cnt value after down", int'(tcnt), 255);
      check("cnt unf", int'(unf), 1);
      check("cnt ovf held", int'(ovf), 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
